// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter: request record and port indices.
package wb_pkg;
    localparam int SW     = 36;
    localparam int VLANES = 4;
    localparam int REG_AW = 5;
    localparam int LANE_W = 32;

    localparam int PORT_S = 0;
    localparam int PORT_V = 1;
    localparam int NPORTS = 2;

    typedef struct packed {
        logic                           valid;
        logic                           is_vec;
        logic [REG_AW-1:0]              addr;
        logic [SW-1:0]                  sdata;
        logic [VLANES-1:0][LANE_W-1:0]  vdata;
        logic [VLANES-1:0]              mask;
    } wb_req_t;
endpackage

// File: rtl/wb_rr_arb.sv
// Two-requester round-robin arbiter for one register-file write port, with a
// fixed-priority override (pipeline) and a saturating starvation counter.
module wb_rr_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic override,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic starve
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic          ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        if (!override) begin
            if (req_a && req_b) begin
                gnt_a    = !ptr_reg;
                gnt_b    = ptr_reg;
                // hand priority to whoever just lost
                ptr_next = !ptr_reg;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
        if (gnt_a || gnt_b || !(req_a || req_b)) begin
            cnt_next = '0;
        end else if (cnt_reg != CW'(STARVE_LIMIT)) begin
            cnt_next = cnt_reg + 1'b1;
        end
        starve = (cnt_next == CW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: merges pipeline, load-unit and multi-cycle results onto the
// scalar and vector register-file write ports through registered outputs.
module writeback_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = 36,
    parameter int VLANES       = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     pipe_s_valid,
    input  logic [wb_pkg::REG_AW-1:0]                pipe_s_addr,
    input  logic [SW-1:0]                            pipe_s_data,
    input  logic                                     pipe_v_valid,
    input  logic [wb_pkg::REG_AW-1:0]                pipe_v_addr,
    input  logic [VLANES-1:0][wb_pkg::LANE_W-1:0]    pipe_v_data,
    input  logic [VLANES-1:0]                        pipe_v_mask,
    input  logic                                     lu_valid,
    output logic                                     lu_ready,
    input  logic                                     lu_is_vec,
    input  logic [wb_pkg::REG_AW-1:0]                lu_addr,
    input  logic [SW-1:0]                            lu_sdata,
    input  logic [VLANES-1:0][wb_pkg::LANE_W-1:0]    lu_vdata,
    input  logic [VLANES-1:0]                        lu_mask,
    input  logic                                     mc_valid,
    output logic                                     mc_ready,
    input  logic                                     mc_is_vec,
    input  logic [wb_pkg::REG_AW-1:0]                mc_addr,
    input  logic [SW-1:0]                            mc_sdata,
    input  logic [VLANES-1:0][wb_pkg::LANE_W-1:0]    mc_vdata,
    input  logic [VLANES-1:0]                        mc_mask,
    output logic                                     s_wr_en,
    output logic [wb_pkg::REG_AW-1:0]                r_write_addr,
    output logic [SW-1:0]                            write_data,
    output logic [wb_pkg::REG_AW-1:0]                v_write_addr,
    output logic [VLANES-1:0][wb_pkg::LANE_W-1:0]    write_vector,
    output logic [VLANES-1:0]                        mask,
    output logic                                     stall_req
);
    import wb_pkg::*;

    wb_req_t lu_req, mc_req, s_win, v_win;

    logic [NPORTS-1:0] pipe_vld, lu_req_p, mc_req_p, lu_gnt_p, mc_gnt_p, starve_p;

    logic                               s_wr_en_reg;
    logic [REG_AW-1:0]                  r_write_addr_reg;
    logic [SW-1:0]                      write_data_reg;
    logic [REG_AW-1:0]                  v_write_addr_reg;
    logic [VLANES-1:0][LANE_W-1:0]      write_vector_reg;
    logic [VLANES-1:0]                  mask_reg;
    logic                               stall_req_reg;

    // No handshake may complete while reset is held.
    always_comb begin
        lu_req = '{valid: lu_valid && rst_n, is_vec: lu_is_vec, addr: lu_addr,
                   sdata: lu_sdata, vdata: lu_vdata, mask: lu_mask};
        mc_req = '{valid: mc_valid && rst_n, is_vec: mc_is_vec, addr: mc_addr,
                   sdata: mc_sdata, vdata: mc_vdata, mask: mc_mask};
    end

    assign pipe_vld = {pipe_v_valid, pipe_s_valid};

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign lu_req_p[gi] = lu_req.valid && ((gi == PORT_V) ? lu_req.is_vec : !lu_req.is_vec);
            assign mc_req_p[gi] = mc_req.valid && ((gi == PORT_V) ? mc_req.is_vec : !mc_req.is_vec);

            wb_rr_arb #(
                .STARVE_LIMIT (STARVE_LIMIT)
            ) u_arb (
                .clk      (clk),
                .rst_n    (rst_n),
                .override (pipe_vld[gi]),
                .req_a    (lu_req_p[gi]),
                .req_b    (mc_req_p[gi]),
                .gnt_a    (lu_gnt_p[gi]),
                .gnt_b    (mc_gnt_p[gi]),
                .starve   (starve_p[gi])
            );
        end
    endgenerate

    assign lu_ready = |lu_gnt_p;
    assign mc_ready = |mc_gnt_p;

    always_comb begin
        s_win = '0;
        v_win = '0;
        if (pipe_s_valid) begin
            s_win.valid = 1'b1;
            s_win.addr  = pipe_s_addr;
            s_win.sdata = pipe_s_data;
        end else if (lu_gnt_p[PORT_S]) begin
            s_win = lu_req;
        end else if (mc_gnt_p[PORT_S]) begin
            s_win = mc_req;
        end
        if (pipe_v_valid) begin
            v_win.valid = 1'b1;
            v_win.addr  = pipe_v_addr;
            v_win.vdata = pipe_v_data;
            v_win.mask  = pipe_v_mask;
        end else if (lu_gnt_p[PORT_V]) begin
            v_win = lu_req;
        end else if (mc_gnt_p[PORT_V]) begin
            v_win = mc_req;
        end
    end

    // Address/data hold between writes; only the enables return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_wr_en_reg      <= 1'b0;
            r_write_addr_reg <= '0;
            write_data_reg   <= '0;
            v_write_addr_reg <= '0;
            write_vector_reg <= '0;
            mask_reg         <= '0;
            stall_req_reg    <= 1'b0;
        end else begin
            s_wr_en_reg <= s_win.valid;
            if (s_win.valid) begin
                r_write_addr_reg <= s_win.addr;
                write_data_reg   <= s_win.sdata;
            end
            mask_reg <= v_win.valid ? v_win.mask : '0;
            if (v_win.valid) begin
                v_write_addr_reg <= v_win.addr;
                write_vector_reg <= v_win.vdata;
            end
            stall_req_reg <= |starve_p;
        end
    end

    assign s_wr_en      = s_wr_en_reg;
    assign r_write_addr = r_write_addr_reg;
    assign write_data   = write_data_reg;
    assign v_write_addr = v_write_addr_reg;
    assign write_vector = write_vector_reg;
    assign mask         = mask_reg;
    assign stall_req    = stall_req_reg;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus reset, starvation and
// mid-transfer reset sequences.
module tb_writeback_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             pipe_s_valid, pipe_v_valid, lu_valid, mc_valid;
    logic             lu_ready, mc_ready, lu_is_vec, mc_is_vec;
    logic [4:0]       pipe_s_addr, pipe_v_addr, lu_addr, mc_addr;
    logic [35:0]      pipe_s_data, lu_sdata, mc_sdata;
    logic [3:0][31:0] pipe_v_data, lu_vdata, mc_vdata;
    logic [3:0]       pipe_v_mask, lu_mask, mc_mask;
    logic             s_wr_en, stall_req;
    logic [4:0]       r_write_addr, v_write_addr;
    logic [35:0]      write_data;
    logic [3:0][31:0] write_vector;
    logic [3:0]       mask;

    writeback_arbiter #(.STARVE_LIMIT(4), .SW(36), .VLANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_s_valid(pipe_s_valid), .pipe_s_addr(pipe_s_addr), .pipe_s_data(pipe_s_data),
        .pipe_v_valid(pipe_v_valid), .pipe_v_addr(pipe_v_addr), .pipe_v_data(pipe_v_data),
        .pipe_v_mask(pipe_v_mask),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_is_vec(lu_is_vec), .lu_addr(lu_addr),
        .lu_sdata(lu_sdata), .lu_vdata(lu_vdata), .lu_mask(lu_mask),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_is_vec(mc_is_vec), .mc_addr(mc_addr),
        .mc_sdata(mc_sdata), .mc_vdata(mc_vdata), .mc_mask(mc_mask),
        .s_wr_en(s_wr_en), .r_write_addr(r_write_addr), .write_data(write_data),
        .v_write_addr(v_write_addr), .write_vector(write_vector), .mask(mask),
        .stall_req(stall_req)
    );

    typedef struct {
        logic ps_v; logic [4:0] ps_a; logic [35:0] ps_d;
        logic pv_v; logic [4:0] pv_a; logic [3:0] pv_m;
        logic lu_v; logic lu_vec; logic [4:0] lu_a; logic [3:0] lu_m;
        logic mc_v; logic mc_vec; logic [4:0] mc_a; logic [3:0] mc_m;
        logic e_lu; logic e_mc;
        logic e_swr; logic [4:0] e_ra; logic [35:0] e_wd;
        logic [4:0] e_va; logic [3:0] e_mask; int e_vsrc; logic e_stall;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl [12];
    vec_t cur;

    // Lane pattern per source: 0 pipe, 1 lu, 2 mc, 3 = all zero.
    function automatic logic [127:0] vpat(input int src, input logic [4:0] a);
        logic [127:0] v;
        v = '0;
        if (src <= 2)
            for (int l = 0; l < 4; l++)
                v[l*32 +: 32] = {4'(src + 12), 12'h000, 8'(l), 3'b000, a};
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pipe_s_valid = v.ps_v; pipe_s_addr = v.ps_a; pipe_s_data = v.ps_d;
        pipe_v_valid = v.pv_v; pipe_v_addr = v.pv_a; pipe_v_mask = v.pv_m;
        pipe_v_data  = vpat(0, v.pv_a);
        lu_valid = v.lu_v; lu_is_vec = v.lu_vec; lu_addr = v.lu_a; lu_mask = v.lu_m;
        lu_sdata = 36'hA_0000_0000 | 36'(v.lu_a); lu_vdata = vpat(1, v.lu_a);
        mc_valid = v.mc_v; mc_is_vec = v.mc_vec; mc_addr = v.mc_a; mc_mask = v.mc_m;
        mc_sdata = 36'hB_0000_0000 | 36'(v.mc_a); mc_vdata = vpat(2, v.mc_a);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " s_wr_en"}, 128'(s_wr_en), 128'd0);
        chk({tag, " r_write_addr"}, 128'(r_write_addr), 128'd0);
        chk({tag, " write_data"}, 128'(write_data), 128'd0);
        chk({tag, " v_write_addr"}, 128'(v_write_addr), 128'd0);
        chk({tag, " write_vector"}, 128'(write_vector), 128'd0);
        chk({tag, " mask"}, 128'(mask), 128'd0);
        chk({tag, " stall_req"}, 128'(stall_req), 128'd0);
        chk({tag, " lu_ready"}, 128'(lu_ready), 128'd0);
        chk({tag, " mc_ready"}, 128'(mc_ready), 128'd0);
    endtask

    initial begin
        //          ps_v ps_a ps_d             pv_v pv_a pv_m   lu_v vec a  m        mc_v vec a  m        rdy lu,mc  swr ra  wd                va  mask   vsrc stall
        tbl[0]  = '{1, 7,  36'h1_2345_6789,  0, 0,  4'h0,  0, 0, 0, 4'h0,       0, 0, 0,  4'h0,       0, 0,  1, 7,  36'h1_2345_6789, 22, 4'h0,     0, 0};
        tbl[1]  = '{0, 0,  36'h0,            0, 0,  4'h0,  0, 0, 0, 4'h0,       0, 0, 0,  4'h0,       0, 0,  0, 7,  36'h1_2345_6789, 22, 4'h0,     0, 0};
        tbl[2]  = '{0, 0,  36'h0,            0, 0,  4'h0,  1, 0, 1, 4'h0,       1, 0, 2,  4'h0,       1, 0,  1, 1,  36'hA_0000_0001, 22, 4'h0,     0, 0};
        tbl[3]  = '{0, 0,  36'h0,            0, 0,  4'h0,  1, 0, 1, 4'h0,       1, 0, 2,  4'h0,       0, 1,  1, 2,  36'hB_0000_0002, 22, 4'h0,     0, 0};
        tbl[4]  = '{0, 0,  36'h0,            0, 0,  4'h0,  1, 0, 1, 4'h0,       1, 0, 2,  4'h0,       1, 0,  1, 1,  36'hA_0000_0001, 22, 4'h0,     0, 0};
        tbl[5]  = '{0, 0,  36'h0,            0, 0,  4'h0,  1, 0, 1, 4'h0,       1, 0, 2,  4'h0,       0, 1,  1, 2,  36'hB_0000_0002, 22, 4'h0,     0, 0};
        tbl[6]  = '{0, 0,  36'h0,            0, 0,  4'h0,  1, 0, 3, 4'h0,       1, 1, 9,  4'b1010,    1, 1,  1, 3,  36'hA_0000_0003, 9,  4'b1010,  2, 0};
        tbl[7]  = '{0, 0,  36'h0,            1, 5,  4'hF,  1, 1, 4, 4'b0011,    0, 0, 0,  4'h0,       0, 0,  0, 3,  36'hA_0000_0003, 5,  4'hF,     0, 0};
        tbl[8]  = '{0, 0,  36'h0,            0, 0,  4'h0,  1, 1, 4, 4'b0011,    1, 1, 6,  4'h0,       1, 0,  0, 3,  36'hA_0000_0003, 4,  4'b0011,  1, 0};
        tbl[9]  = '{0, 0,  36'h0,            0, 0,  4'h0,  0, 0, 0, 4'h0,       1, 1, 6,  4'h0,       0, 1,  0, 3,  36'hA_0000_0003, 6,  4'h0,     2, 0};
        tbl[10] = '{1, 31, 36'hF_FFFF_FFFF,  1, 0,  4'b0101, 1, 0, 8, 4'h0,     1, 1, 10, 4'h0,       0, 0,  1, 31, 36'hF_FFFF_FFFF, 0,  4'b0101,  0, 0};
        tbl[11] = '{0, 0,  36'h0,            0, 0,  4'h0,  0, 0, 0, 4'h0,       0, 0, 0,  4'h0,       0, 0,  0, 31, 36'hF_FFFF_FFFF, 0,  4'h0,     0, 0};

        // Reset held with every valid high
        rst_n = 1'b0;
        cur = '{default: '0};
        cur.ps_v = 1; cur.ps_a = 21; cur.ps_d = 36'h15;
        cur.pv_v = 1; cur.pv_a = 22; cur.pv_m = 4'b1100;
        cur.lu_v = 1; cur.lu_a = 2; cur.mc_v = 1; cur.mc_vec = 1; cur.mc_a = 3;
        drive(cur);
        repeat (2) @(posedge clk);
        #1 chk_zero_outputs("reset");
        cur.ps_v = 0; cur.pv_v = 0;
        drive(cur);
        #1 chk("reset lu_ready pipe idle", 128'(lu_ready), 128'd0);
        chk("reset mc_ready pipe idle", 128'(mc_ready), 128'd0);
        cur.ps_v = 1; cur.pv_v = 1;
        drive(cur);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("release lu_ready", 128'(lu_ready), 128'd0);
        @(posedge clk);
        #1 chk("release s_wr_en", 128'(s_wr_en), 128'd1);
        chk("release r_write_addr", 128'(r_write_addr), 128'd21);
        chk("release write_data", 128'(write_data), 128'h15);
        chk("release mask", 128'(mask), 128'b1100);
        chk("release write_vector", 128'(write_vector), vpat(0, 5'd22));
        $display("reset release: s_wr_en=%0b r_addr=%0d v_addr=%0d mask=%b", s_wr_en, r_write_addr, v_write_addr, mask);

        // Table-driven vectors, one clock each
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d lu_ready", i), 128'(lu_ready), 128'(tbl[i].e_lu));
            chk($sformatf("row%0d mc_ready", i), 128'(mc_ready), 128'(tbl[i].e_mc));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d s_wr_en", i), 128'(s_wr_en), 128'(tbl[i].e_swr));
            chk($sformatf("row%0d r_write_addr", i), 128'(r_write_addr), 128'(tbl[i].e_ra));
            chk($sformatf("row%0d write_data", i), 128'(write_data), 128'(tbl[i].e_wd));
            chk($sformatf("row%0d v_write_addr", i), 128'(v_write_addr), 128'(tbl[i].e_va));
            chk($sformatf("row%0d mask", i), 128'(mask), 128'(tbl[i].e_mask));
            chk($sformatf("row%0d write_vector", i), 128'(write_vector), vpat(tbl[i].e_vsrc, tbl[i].e_va));
            chk($sformatf("row%0d stall_req", i), 128'(stall_req), 128'(tbl[i].e_stall));
            $display("row %0d: lu_rdy=%0b mc_rdy=%0b s_wr_en=%0b r_addr=%0d wdata=%h v_addr=%0d mask=%b stall=%0b",
                     i, tbl[i].e_lu, tbl[i].e_mc, s_wr_en, r_write_addr, write_data, v_write_addr, mask, stall_req);
        end

        // Starvation: pipe holds the scalar port for 6 cycles while lu waits
        cur = '{default: '0};
        cur.lu_v = 1; cur.lu_a = 12;
        for (int k = 0; k < 6; k++) begin
            cur.ps_v = 1; cur.ps_a = 5'(13 + k); cur.ps_d = 36'h100 + 36'(k);
            drive(cur);
            #1 chk($sformatf("starve%0d lu_ready", k), 128'(lu_ready), 128'd0);
            @(posedge clk);
            #1;
            chk($sformatf("starve%0d s_wr_en", k), 128'(s_wr_en), 128'd1);
            chk($sformatf("starve%0d r_write_addr", k), 128'(r_write_addr), 128'(13 + k));
            chk($sformatf("starve%0d stall_req", k), 128'(stall_req), 128'((k + 1) >= 4));
            $display("starve %0d: r_addr=%0d stall=%0b", k, r_write_addr, stall_req);
        end
        cur.ps_v = 0;
        drive(cur);
        #1 chk("starve grant lu_ready", 128'(lu_ready), 128'd1);
        chk("starve grant stall_req", 128'(stall_req), 128'd1);
        @(posedge clk);
        #1;
        chk("starve done s_wr_en", 128'(s_wr_en), 128'd1);
        chk("starve done r_write_addr", 128'(r_write_addr), 128'd12);
        chk("starve done write_data", 128'(write_data), 128'hA_0000_000C);
        chk("starve done stall_req", 128'(stall_req), 128'd0);
        $display("starve release: r_addr=%0d stall=%0b", r_write_addr, stall_req);

        // Reset in the middle of a contended transfer
        cur = '{default: '0};
        cur.lu_v = 1; cur.lu_a = 1; cur.mc_v = 1; cur.mc_a = 2;
        cur.pv_v = 1; cur.pv_a = 7; cur.pv_m = 4'hF;
        drive(cur);
        #1 chk("midrst first lu_ready", 128'(lu_ready), 128'd1);
        @(posedge clk);
        #1 chk("midrst first r_write_addr", 128'(r_write_addr), 128'd1);
        chk("midrst first mask", 128'(mask), 128'hF);
        #1 chk("midrst second mc_ready", 128'(mc_ready), 128'd1);
        rst_n = 1'b0;
        #1 chk_zero_outputs("midrst");
        $display("mid reset: s_wr_en=%0b mask=%b stall=%0b", s_wr_en, mask, stall_req);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("midrst release lu_ready", 128'(lu_ready), 128'd1);
        chk("midrst release mc_ready", 128'(mc_ready), 128'd0);
        @(posedge clk);
        #1 chk("midrst release r_write_addr", 128'(r_write_addr), 128'd1);
        chk("midrst release write_data", 128'(write_data), 128'hA_0000_0001);
        $display("after mid reset: r_addr=%0d wdata=%h", r_write_addr, write_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage: collects completed results from the main pipeline, the load unit and the multi-cycle unit.
- Drives the single scalar write port and the single vector write port of the decode-stage register files, through registered outputs.
- Pipeline results always win their port. Load and multi-cycle results use valid/ready and are round-robin arbitrated per port.
- A per-port starvation counter raises a stall request to the hazard unit.

Parameters:
- STARVE_LIMIT, 4, consecutive blocked cycles of a waiting lu/mc request before stall_req asserts (≥1).
- SW, 36, scalar data width.
- VLANES, 4, vector lanes of 32 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_s_valid  in  1  pipeline scalar result valid (no backpressure)
- pipe_s_addr  in  5  scalar destination
- pipe_s_data  in  36  scalar result
- pipe_v_valid  in  1  pipeline vector result valid (no backpressure)
- pipe_v_addr  in  5  vector destination
- pipe_v_data  in  32x4  vector result
- pipe_v_mask  in  4  lane write enables
- lu_valid / mc_valid  in  1  result valid
- lu_ready / mc_ready  out  1  combinational grant; transfer when valid&&ready
- lu_is_vec / mc_is_vec  in  1  target port select: 1 = vector, 0 = scalar
- lu_addr / mc_addr  in  5  destination register
- lu_sdata / mc_sdata  in  36  scalar payload
- lu_vdata / mc_vdata  in  32x4  vector payload
- lu_mask / mc_mask  in  4  lane mask (vector only)
- s_wr_en  out  1  scalar register file write enable
- r_write_addr  out  5  scalar write address
- write_data  out  36  scalar write data
- v_write_addr  out  5  vector write address
- write_vector  out  32x4  vector write data
- mask  out  4  per-lane vector write enable; 0 = no vector write
- stall_req  out  1  request the hazard unit to freeze the pipeline

Behaviour:
- Reset, asynchronous: every output register, round-robin pointer and starvation counter is 0. stall_req=0, s_wr_en=0, mask=0, all data and address outputs 0. Reset mid-transfer discards any in-flight write; no handshake is outstanding after reset.
- Port candidates per cycle:
  - Scalar port: pipe_s, lu if !lu_is_vec, mc if !mc_is_vec.
  - Vector port: pipe_v, lu if lu_is_vec, mc if mc_is_vec.
- Grant rules:
  - pipe_*_valid wins its port unconditionally. The pipeline is never dropped or stalled by this block.
  - Otherwise, if lu and mc both request the same port, the per-port RR pointer decides: 0 favours lu, 1 favours mc. The pointer flips to the loser only after a contended grant.
  - A single lu or mc requester wins its port if the pipe is idle there.
  - lu and mc on different ports are both granted in the same cycle.
- Ready: lu_ready/mc_ready = grant. They are combinational from the valid, is_vec and pipe_valid inputs only, and do not depend on the source's own ready.
- Latency: the granted payload appears on the write outputs the next clock edge, exactly 1 cycle.
  - s_wr_en is high for one cycle per accepted scalar result.
  - mask equals the granted mask, so a vector write with mask 0 is a legal no-op write.
  - With no grant: s_wr_en=0 and mask=0; address and data hold their last values.
- Payload is forwarded unchanged. Address 0 is not special-cased here.
- Starvation, per port:
  - The counter increments each cycle in which a valid lu/mc request for that port is not granted.
  - It clears when that port grants an lu/mc request, or when no lu/mc request is pending for the port.
  - It saturates at STARVE_LIMIT.
- stall_req:
  - Registered. Asserts the cycle after any port counter reaches STARVE_LIMIT.
  - Stays high until that port's blocked request is granted; deasserts the cycle after that grant.
- A pipe result arriving while stall_req=1 is still accepted normally.

Decomposition:
- Shared package wb_pkg:
  - wb_req_t struct: valid, is_vec, addr, sdata, vdata[3:0], mask.
  - Constants: SW=36, VLANES=4, REG_AW=5.
- One natural sub-module, wb_rr_arb: 2-requester round-robin arbiter with fixed-priority override input and pointer flop. It is instantiated once per port and owns that port's starvation counter.

Test Plan:
- Reset: hold rst_n=0 with all valids high -> all outputs 0, lu_ready=mc_ready=0 while in reset; release -> first grants appear, outputs update 1 cycle later.
- Pipe only: pipe_s_valid=1, addr=7, data=36'h1_2345_6789 -> next cycle s_wr_en=1, r_write_addr=7, write_data=36'h1_2345_6789; the following idle cycle s_wr_en=0.
- Contention: lu and mc both scalar and valid for 4 cycles, pipe idle -> grants lu, mc, lu, mc; one s_wr_en pulse per cycle with matching addresses.
- Split ports: lu scalar (addr 3) plus mc vector (addr 9, mask 4'b1010) in the same cycle -> both ready=1; next cycle s_wr_en=1 with r_write_addr=3, and v_write_addr=9 with mask=4'b1010.
- Starvation: pipe_s_valid=1 for 6 cycles with lu scalar waiting, STARVE_LIMIT=4 -> stall_req rises the cycle after the 4th blocked cycle. The pipe keeps writing throughout. When the pipe drops, lu is granted and stall_req falls 1 cycle after the grant.
- Reset mid-operation: assert rst_n=0 during a contended transfer -> outputs and stall_req go to 0 immediately; after release the RR pointer restarts favouring lu.
